usb_tx_bit_timer: RTL
=====================

# usb_tx_bit_timer

Parametrised bit/byte/packet timing engine for the USB transmit path. It generalises the fixed divide-by-25, 8-bit, 7-bit-packet timer into a single state-machine-driven block. It adds explicit bit-stuff periods, a configurable EOP duration, start/busy handshaking and stall via enable. It sits between the TX controller FSM (start, stuff_req, packet_size) and the TX encoder/shifter, which consumes the strobes.

## Interface
- CLK_DIV, 25, clock cycles per bit period; must be ≥2
- BITS_PER_BYTE, 8, data bits per byte; must be ≥2
- SIZE_W, 7, width of packet_size and byte_idx
- EOP_BITS, 2, bit periods of EOP; must be ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort to IDLE
- enable  in  1  advances the phase counter; low stalls everything
- start  in  1  one-cycle request to begin a packet
- packet_size  in  SIZE_W  byte count, latched on accepted start
- stuff_req  in  1  insert a stuff bit after the data bit now ending
- busy  out  1  high in any state other than IDLE
- bit_strobe  out  1  pulse on the last cycle of every bit period (DATA/STUFF/EOP)
- byte_done  out  1  pulse on the last cycle of each byte's final data bit
- packet_done  out  1  pulse with the final byte_done
- stuff_slot  out  1  high throughout a STUFF period
- eop_active  out  1  high throughout EOP
- eop_done  out  1  pulse on the last cycle of EOP
- mid_strobe  out  1  mid-bit pulse (see Configuration)
- bit_idx  out  $clog2(BITS_PER_BYTE)  current data bit in byte
- byte_idx  out  SIZE_W  current byte in packet

## Operation
- States: IDLE, DATA, STUFF, EOP.
- Priority on each edge: rst > clear > start > normal advance.
- rst/clear: state IDLE, phase, bit_idx and byte_idx all 0, latched size 0. All pulses stay low in that cycle and the next.
- IDLE + start:
  - packet_size≠0 → DATA.
  - packet_size=0 → EOP directly; no byte_done or packet_done.
  - start outside IDLE is ignored.
- Phase: counts 0..CLK_DIV-1 while enable=1 and state≠IDLE, then wraps to 0. It holds when enable=0.
- Bit end is the cycle with phase=CLK_DIV-1 and enable=1. Strobes are combinational decode of registered state and enable, and are valid in that cycle.
- DATA bit end:
  - bit_idx increments.
  - At BITS_PER_BYTE-1: byte_done, bit_idx←0, byte_idx increments.
  - At the final byte: packet_done.
  - Next state: STUFF if stuff_req=1, else EOP if the packet is done, else DATA.
- STUFF bit end: → DATA, or → EOP if packet_done already fired. bit_idx and byte_idx hold. stuff_req is ignored in STUFF.
- EOP: an internal count runs 0..EOP_BITS-1. The final bit end raises eop_done → IDLE. busy is low from the next cycle.
- byte_idx wraps modulo 2^SIZE_W only as a result of the packet_size compare. packet_size=2^SIZE_W-1 is the maximum.

## Timing
- Reset values: busy, all strobes, stuff_slot, eop_active and mid_strobe are 0; bit_idx=0 and byte_idx=0.
- Cycle numbering: start accepted in cycle 0, with enable held high.
  - DATA phase 0 is in cycle 1.
  - The first bit_strobe is in cycle CLK_DIV.
- The k-th bit period (stuff and EOP included) ends in cycle k·CLK_DIV.
- Without stuffing, eop_done occurs in cycle (N·BITS_PER_BYTE+EOP_BITS)·CLK_DIV.
- Each stuff bit adds CLK_DIV cycles.
- Each cycle with enable=0 adds one cycle.
- start coincident with eop_done is ignored, because state is still EOP.

## Configuration
- USB_TX_TIMER_MID_STROBE_EN defined: mid_strobe pulses when phase=(CLK_DIV/2)-1 and enable=1 in DATA, STUFF and EOP. This serves encoder/loopback sampling.
- Not defined: mid_strobe is tied to 0 and the comparator is not built.
- The port exists in both cases.

## Structure
- Package usb_tx_pkg holds:
  - the tx_timer_state_t enum (IDLE, DATA, STUFF, EOP);
  - default constants USB_TX_CLK_DIV=25, USB_TX_BITS_PER_BYTE=8 and USB_TX_EOP_BITS=2.
- One sub-module, tx_phase_counter: parametrised by CLK_DIV, with enable, clear and a wrap output. It replaces the ad hoc per-level counters.
- The FSM, bit/byte counters and output decode live in the top module.

## Test plan
- Defaults, size=2, no stuffing, start in cycle 0:
  - byte_done in cycles 200 and 400;
  - packet_done in cycle 400;
  - eop_active over cycles 401–450;
  - eop_done in cycle 450;
  - busy low from cycle 451.
- Size=1, stuff_req high in cycle 100 (end of bit 4):
  - stuff_slot over cycles 101–125;
  - bit_idx holds at 4;
  - byte_done and packet_done in cycle 225;
  - eop_done in cycle 275.
- Stuff on the last bit, size=1, stuff_req in cycle 200:
  - packet_done in cycle 200;
  - STUFF over cycles 201–225;
  - EOP over cycles 226–275;
  - eop_done in cycle 275.
- Size=1, enable low for cycles 30–39: every later event is shifted by +10 (byte_done in cycle 210, eop_done in cycle 260). Also check start during busy is ignored and size=0 gives eop_done in cycle 50 with no packet_done.
- clear in cycle 430 of the size=2 case: IDLE in cycle 431, no eop_done, busy=0, counters 0. Check rst in cycle 430 gives the same result.
- With USB_TX_TIMER_MID_STROBE_EN: mid_strobe in cycles 12, 37, 62…. Without the macro, mid_strobe stays 0 for the whole packet.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and default timing constants for the USB transmit bit timer.
package usb_tx_pkg;

  localparam int unsigned USB_TX_CLK_DIV       = 25;
  localparam int unsigned USB_TX_BITS_PER_BYTE = 8;
  localparam int unsigned USB_TX_EOP_BITS      = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StStuff = 2'd2,
    StEop   = 2'd3
  } tx_timer_state_t;

endpackage

// File: rtl/tx_phase_counter.sv
// Bit-period phase counter: counts 0..CLK_DIV-1 while enabled, wraps to 0.
// wrap is high in the final cycle of a period (phase at max and enable high).
module tx_phase_counter #(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned PHASE_W = $clog2(CLK_DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  localparam logic [PHASE_W-1:0] PhaseMax = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;

  assign phase = phase_q;
  assign wrap  = enable && (phase_q == PhaseMax);

  // Next phase: clear wins, otherwise advance/wrap only when enabled.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = wrap ? '0 : phase_q + PHASE_W'(1);
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/usb_tx_bit_timer.sv
// USB TX bit/byte/packet timing engine: sequences DATA, STUFF and EOP bit
// periods and emits strobes for the encoder/shifter.
// Optional: define USB_TX_TIMER_MID_STROBE_EN to build the mid-bit strobe;
// otherwise mid_strobe is tied low.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV       = USB_TX_CLK_DIV,
  parameter int unsigned BITS_PER_BYTE = USB_TX_BITS_PER_BYTE,
  parameter int unsigned SIZE_W        = 7,
  parameter int unsigned EOP_BITS      = USB_TX_EOP_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             enable,
  input  logic                             start,
  input  logic [SIZE_W-1:0]                packet_size,
  input  logic                             stuff_req,
  output logic                             busy,
  output logic                             bit_strobe,
  output logic                             byte_done,
  output logic                             packet_done,
  output logic                             stuff_slot,
  output logic                             eop_active,
  output logic                             eop_done,
  output logic                             mid_strobe,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_idx,
  output logic [SIZE_W-1:0]                byte_idx
);

  localparam int unsigned PhaseW = $clog2(CLK_DIV);
  localparam int unsigned BitW   = $clog2(BITS_PER_BYTE);
  localparam int unsigned EopW   = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

  localparam logic [BitW-1:0] BitMax = BitW'(BITS_PER_BYTE - 1);
  localparam logic [EopW-1:0] EopMax = EopW'(EOP_BITS - 1);

  tx_timer_state_t   state_q, state_d;
  logic [BitW-1:0]   bit_idx_q, bit_idx_d;
  logic [SIZE_W-1:0] byte_idx_q, byte_idx_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [EopW-1:0]   eop_cnt_q, eop_cnt_d;
  // Remembers that packet_done already fired, so a trailing STUFF goes to EOP.
  logic              pkt_done_q, pkt_done_d;

  logic              cnt_en;
  logic              wrap;
  logic [PhaseW-1:0] phase;
  logic              byte_end, last_byte, eop_end;

  assign cnt_en = enable && (state_q != StIdle);

  tx_phase_counter #(
    .CLK_DIV (CLK_DIV),
    .PHASE_W (PhaseW)
  ) u_phase (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (cnt_en),
    .phase  (phase),
    .wrap   (wrap)
  );

  // Next-state, counter updates and internal event decode.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    size_d     = size_q;
    eop_cnt_d  = eop_cnt_q;
    pkt_done_d = pkt_done_q;
    byte_end   = 1'b0;
    last_byte  = 1'b0;
    eop_end    = 1'b0;

    if (clear) begin
      state_d    = StIdle;
      bit_idx_d  = '0;
      byte_idx_d = '0;
      size_d     = '0;
      eop_cnt_d  = '0;
      pkt_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            size_d     = packet_size;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            eop_cnt_d  = '0;
            pkt_done_d = 1'b0;
            state_d    = (packet_size == '0) ? StEop : StData;
          end
        end
        StData: begin
          if (wrap) begin
            if (bit_idx_q == BitMax) begin
              byte_end  = 1'b1;
              bit_idx_d = '0;
              if (byte_idx_q == size_q - SIZE_W'(1)) begin
                last_byte  = 1'b1;
                pkt_done_d = 1'b1;
                byte_idx_d = '0;
              end else begin
                byte_idx_d = byte_idx_q + SIZE_W'(1);
              end
            end else begin
              bit_idx_d = bit_idx_q + BitW'(1);
            end
            if (stuff_req) begin
              state_d = StStuff;
            end else if (last_byte) begin
              state_d = StEop;
            end
          end
        end
        StStuff: begin
          if (wrap) begin
            state_d = pkt_done_q ? StEop : StData;
          end
        end
        StEop: begin
          if (wrap) begin
            if (eop_cnt_q == EopMax) begin
              eop_end   = 1'b1;
              eop_cnt_d = '0;
              state_d   = StIdle;
            end else begin
              eop_cnt_d = eop_cnt_q + EopW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      size_q     <= '0;
      eop_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      size_q     <= size_d;
      eop_cnt_q  <= eop_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Output decode; pulses are suppressed in a reset or clear cycle.
  always_comb begin
    busy        = (state_q != StIdle);
    stuff_slot  = (state_q == StStuff);
    eop_active  = (state_q == StEop);
    bit_strobe  = wrap && !clear && !rst;
    byte_done   = byte_end && !rst;
    packet_done = last_byte && !rst;
    eop_done    = eop_end && !rst;
    bit_idx     = bit_idx_q;
    byte_idx    = byte_idx_q;
  end

`ifdef USB_TX_TIMER_MID_STROBE_EN
  localparam logic [PhaseW-1:0] MidPhase = PhaseW'(CLK_DIV / 2 - 1);
  assign mid_strobe = cnt_en && (phase == MidPhase) && !clear && !rst;
`else
  logic unused_phase;
  assign unused_phase = ^phase;
  assign mid_strobe   = 1'b0;
`endif

endmodule
